// File: rtl/receive_adc_if.sv
// Parallel-side and serial-pin signals of the dual-channel ADC capture block.
// slave is the capture block, master is whoever requests frames and drives the pins.
interface receive_adc_if #(
    parameter int unsigned DATA_W = 12
);
    logic              start;
    logic              sdata0;
    logic              sdata1;
    logic              cs_n;
    logic [DATA_W-1:0] data0;
    logic [DATA_W-1:0] data1;
    logic              data_valid;
    logic              busy;
    logic              frame_err;

    modport master (
        output start, sdata0, sdata1,
        input  cs_n, data0, data1, data_valid, busy, frame_err
    );

    modport slave (
        input  start, sdata0, sdata1,
        output cs_n, data0, data1, data_valid, busy, frame_err
    );
endinterface

// File: rtl/receive_adc.sv
// Serial capture of two MSB-first ADC channels, one FRAME_W-bit frame per start request,
// presenting the low DATA_W bits of each channel with a one-cycle valid strobe.
module receive_adc #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned FRAME_W   = 16,
    parameter int unsigned QUIET_CYC = 2
) (
    input logic            i_sclk,
    input logic            i_rst_n,
    receive_adc_if.slave   io_adc
);
    localparam int unsigned CW = $clog2(FRAME_W);
    localparam int unsigned QW = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StQuiet} state_e;

    state_e             r_state;
    state_e             w_state_next;
    logic [CW-1:0]      r_bit_cnt;
    logic [QW-1:0]      r_quiet_cnt;
    // Only the older FRAME_W-1 bits are stored; the newest bit comes straight from the pin.
    logic [FRAME_W-2:0] r_sr0;
    logic [FRAME_W-2:0] r_sr1;
    logic [FRAME_W-1:0] w_frame0;
    logic [FRAME_W-1:0] w_frame1;
    logic [DATA_W-1:0]  r_data0;
    logic [DATA_W-1:0]  r_data1;
    logic               r_data_valid;
    logic               r_frame_err;
    logic               w_last_bit;
    logic               w_quiet_done;
    logic               w_cs_n;
    logic               w_busy;

    assign w_frame0     = {r_sr0, io_adc.sdata0};
    assign w_frame1     = {r_sr1, io_adc.sdata1};
    assign w_last_bit   = (r_state == StShift) && (r_bit_cnt == CW'(FRAME_W - 1));
    assign w_quiet_done = (r_state == StQuiet) && (r_quiet_cnt == QW'(QUIET_CYC - 1));

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (io_adc.start) w_state_next = StShift;
            StShift: if (w_last_bit)   w_state_next = StQuiet;
            StQuiet: if (w_quiet_done) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_cs_n = 1'b1;
        w_busy = 1'b1;
        unique case (r_state)
            StIdle:  w_busy = 1'b0;
            StShift: w_cs_n = 1'b0;
            StQuiet: w_cs_n = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge i_sclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit_cnt    <= '0;
            r_quiet_cnt  <= '0;
            r_sr0        <= '0;
            r_sr1        <= '0;
            r_data0      <= '0;
            r_data1      <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_adc.start) begin
                        r_bit_cnt <= '0;
                        r_sr0     <= '0;
                        r_sr1     <= '0;
                    end
                end
                StShift: begin
                    r_sr0     <= w_frame0[FRAME_W-2:0];
                    r_sr1     <= w_frame1[FRAME_W-2:0];
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_last_bit) begin
                        r_data0      <= w_frame0[DATA_W-1:0];
                        r_data1      <= w_frame1[DATA_W-1:0];
                        r_data_valid <= 1'b1;
                        r_frame_err  <= (|w_frame0[FRAME_W-1:DATA_W])
                                      | (|w_frame1[FRAME_W-1:DATA_W]);
                        r_quiet_cnt  <= '0;
                    end
                end
                StQuiet: r_quiet_cnt <= r_quiet_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign io_adc.cs_n       = w_cs_n;
    assign io_adc.busy       = w_busy;
    assign io_adc.data0      = r_data0;
    assign io_adc.data1      = r_data1;
    assign io_adc.data_valid = r_data_valid;
    assign io_adc.frame_err  = r_frame_err;
endmodule

// File: tb/tb_receive_adc.sv
// Bench for receive_adc: a serial ADC model feeds queued frames and a scoreboard
// checks every data_valid strobe against the expected samples.
module tb_receive_adc;
    localparam int DATA_W    = 12;
    localparam int FRAME_W   = 16;
    localparam int QUIET_CYC = 2;

    typedef struct packed {
        logic [FRAME_W-1:0] f0;
        logic [FRAME_W-1:0] f1;
    } frame_t;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d0;
    } exp_t;

    logic   sclk  = 1'b0;
    logic   rst_n = 1'b1;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     n_dv    = 0;
    int     dv_cyc[$];
    frame_t frame_q[$];
    exp_t   exp_q[$];

    receive_adc_if #(.DATA_W(DATA_W)) adc_if ();

    receive_adc #(
        .DATA_W    (DATA_W),
        .FRAME_W   (FRAME_W),
        .QUIET_CYC (QUIET_CYC)
    ) dut (
        .i_sclk  (sclk),
        .i_rst_n (rst_n),
        .io_adc  (adc_if)
    );

    always #5 sclk = ~sclk;
    always @(posedge sclk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input frame_t f);
        exp_t e;
        e.d0  = f.f0[DATA_W-1:0];
        e.d1  = f.f1[DATA_W-1:0];
        e.err = (|f.f0[FRAME_W-1:DATA_W]) || (|f.f1[FRAME_W-1:DATA_W]);
        return e;
    endfunction

    // Serial ADC: presents the next bit on the falling edge while cs_n is low.
    int     bit_idx = 0;
    frame_t cur;
    always @(negedge sclk) begin
        if (!rst_n || adc_if.cs_n !== 1'b0) begin
            bit_idx       = 0;
            adc_if.sdata0 = 1'b0;
            adc_if.sdata1 = 1'b0;
        end else begin
            if (bit_idx == 0) begin
                cur = '0;
                if (frame_q.size() > 0) cur = frame_q.pop_front();
                exp_q.push_back(model(cur));
            end
            adc_if.sdata0 = cur.f0[FRAME_W-1-bit_idx];
            adc_if.sdata1 = cur.f1[FRAME_W-1-bit_idx];
            bit_idx = (bit_idx == FRAME_W - 1) ? 0 : bit_idx + 1;
        end
    end

    always @(negedge sclk) begin
        exp_t e;
        if (rst_n && adc_if.data_valid === 1'b1) begin
            n_dv++;
            dv_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("dv_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data0", adc_if.data0, e.d0);
                chk("data1", adc_if.data1, e.d1);
                chk("frame_err", adc_if.frame_err, e.err);
            end
        end
    end

    task automatic push_frame(input logic [FRAME_W-1:0] f0, input logic [FRAME_W-1:0] f1);
        frame_t f;
        f.f0 = f0;
        f.f1 = f1;
        frame_q.push_back(f);
    endtask

    // Returns with the bench on the falling edge right after start was sampled.
    task automatic pulse_start();
        @(negedge sclk);
        adc_if.start = 1'b1;
        @(negedge sclk);
        adc_if.start = 1'b0;
    endtask

    task automatic watch(input int max_cyc, output int lows, output int done_off);
        lows     = 0;
        done_off = -1;
        for (int off = 0; off < max_cyc; off++) begin
            if (adc_if.busy === 1'b0) begin
                done_off = off;
                break;
            end
            if (adc_if.cs_n === 1'b0) lows++;
            @(negedge sclk);
        end
        if (done_off < 0) chk("watch_timeout", 1, 0);
    endtask

    initial begin
        int lows, done_off, base, bad, falls, hi, sz;
        logic prev;
        int runs[$];

        adc_if.start = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        chk("rst_cs_n", adc_if.cs_n, 1);
        chk("rst_data0", adc_if.data0, 0);
        chk("rst_data1", adc_if.data1, 0);
        chk("rst_dv", adc_if.data_valid, 0);
        chk("rst_busy", adc_if.busy, 0);
        chk("rst_err", adc_if.frame_err, 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge sclk);
            if (adc_if.cs_n !== 1'b1 || adc_if.busy !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);

        // Single frame
        base = n_dv;
        push_frame(16'h0ABC, 16'h0123);
        pulse_start();
        watch(40, lows, done_off);
        chk("single_cs_low", lows, FRAME_W);
        chk("single_busy_off", done_off, FRAME_W + QUIET_CYC);
        chk("single_dv_cnt", n_dv - base, 1);

        // Back-to-back frames with start held high
        base = n_dv;
        push_frame(16'h0FFF, 16'h0000);
        push_frame(16'h0800, 16'h0001);
        push_frame(16'h0000, 16'h0FFF);
        @(negedge sclk);
        adc_if.start = 1'b1;
        falls = 0;
        hi    = 0;
        prev  = 1'b1;
        for (int i = 0; i < 100 && n_dv < base + 3; i++) begin
            @(negedge sclk);
            if (adc_if.cs_n === 1'b0 && prev) begin
                falls++;
                if (falls > 1) runs.push_back(hi);
                if (falls == 3) adc_if.start = 1'b0;
            end
            hi   = (adc_if.cs_n === 1'b1) ? hi + 1 : 0;
            prev = adc_if.cs_n;
        end
        adc_if.start = 1'b0;
        chk("b2b_dv_cnt", n_dv - base, 3);
        sz = dv_cyc.size();
        if (sz >= 3) begin
            chk("b2b_gap1", dv_cyc[sz-2] - dv_cyc[sz-3], FRAME_W + 1 + QUIET_CYC);
            chk("b2b_gap2", dv_cyc[sz-1] - dv_cyc[sz-2], FRAME_W + 1 + QUIET_CYC);
        end
        chk("b2b_cs_runs", runs.size(), 2);
        foreach (runs[i]) chk("b2b_cs_high", runs[i], QUIET_CYC + 1);
        watch(40, lows, done_off);

        // Leading-bit error, then a clean frame
        push_frame(16'h0555, 16'h8555);
        pulse_start();
        watch(40, lows, done_off);
        chk("err_held", adc_if.frame_err, 1);
        push_frame(16'h0ABC, 16'h0123);
        pulse_start();
        watch(40, lows, done_off);
        chk("err_cleared", adc_if.frame_err, 0);

        // Reset at the 8th sample
        push_frame(16'h0F0F, 16'h00F0);
        pulse_start();
        repeat (8) @(negedge sclk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", adc_if.cs_n, 1);
        chk("mid_rst_data0", adc_if.data0, 0);
        chk("mid_rst_data1", adc_if.data1, 0);
        chk("mid_rst_busy", adc_if.busy, 0);
        exp_q.delete();
        frame_q.delete();
        base = n_dv;
        repeat (5) @(negedge sclk);
        rst_n = 1'b1;
        repeat (3) @(negedge sclk);
        chk("mid_rst_no_dv", n_dv - base, 0);
        push_frame(16'h0321, 16'h0456);
        pulse_start();
        watch(40, lows, done_off);
        chk("post_rst_dv_cnt", n_dv - base, 1);

        // start pulses during SHIFT and QUIET are ignored
        base = n_dv;
        push_frame(16'h0777, 16'h0888);
        pulse_start();
        for (int off = 0; off < 40; off++) begin
            adc_if.start = (off == 5 || off == FRAME_W);
            @(negedge sclk);
        end
        adc_if.start = 1'b0;
        chk("ignore_dv_cnt", n_dv - base, 1);
        chk("ignore_busy", adc_if.busy, 0);
        chk("ignore_cs_n", adc_if.cs_n, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
